sid_write_sequencer: RTL



---
 rtl/sid_pkg.sv | 30 +++
 rtl/sid_wr_fifo.sv | 57 +++++
 rtl/sid_write_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/sid_pkg.sv
// Shared constants for the SID host write path: register map limits, entry
// layout and sequencer state encoding.
package sid_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 8;

    localparam logic [ADDR_W-1:0] REG_FC_LO    = 5'h15;
    localparam logic [ADDR_W-1:0] REG_FC_HI    = 5'h16;
    localparam logic [ADDR_W-1:0] REG_RES_FILT = 5'h17;
    localparam logic [ADDR_W-1:0] REG_MODE_VOL = 5'h18;
    localparam logic [ADDR_W-1:0] REG_LAST_WR  = 5'h18;

    // Queue entries are packed {delay, addr, data}, data in the LSBs.
    function automatic int unsigned entry_width(input int unsigned delay_w);
        return delay_w + ADDR_W + DATA_W;
    endfunction

    // Addresses above REG_LAST_WR are the SID read-only registers.
    function automatic logic addr_writable(input logic [ADDR_W-1:0] addr);
        return addr <= REG_LAST_WR;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_WRITE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/sid_wr_fifo.sv
// Synchronous first-word-fall-through FIFO with flush and occupancy output.
module sid_wr_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 29
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_q + LW'(push_ok) - LW'(pop_ok);
        end
    end

endmodule

// File: rtl/sid_write_sequencer.sv
// Replays queued, timestamped host register writes onto the SID register bus,
// spacing each write by its delay counted in clkEn ticks.
module sid_write_sequencer
    import sid_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned DELAY_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clkEn,
    input  logic                    iValid,
    output logic                    oReady,
    input  logic [DELAY_W-1:0]      iDelay,
    input  logic [4:0]              iAddr,
    input  logic [7:0]              iData,
    input  logic                    iPause,
    input  logic                    iFlush,
    output logic                    oWE,
    output logic [4:0]              oAddr,
    output logic [7:0]              oData,
    output logic [$clog2(DEPTH):0]  oLevel,
    output logic                    oBusy,
    output logic                    oDropped
);

    localparam int unsigned ENTRY_W = entry_width(DELAY_W);

    seq_state_e          state_q, state_d;
    logic [DELAY_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
    logic [DATA_W-1:0]   pend_data_q, pend_data_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                dropped_q, dropped_d;

    logic [ENTRY_W-1:0]  head;
    logic [DELAY_W-1:0]  head_delay;
    logic [ADDR_W-1:0]   head_addr;
    logic [DATA_W-1:0]   head_data;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;

    assign oReady = !fifo_full && !iFlush;
    assign push   = iValid && oReady;
    // Pause stalls the IDLE pop too, so the queue can fill while frozen.
    assign pop    = (state_q == ST_IDLE) && !fifo_empty && !iPause && !iFlush;

    assign head_delay = head[ENTRY_W-1 -: DELAY_W];
    assign head_addr  = head[DATA_W +: ADDR_W];
    assign head_data  = head[DATA_W-1:0];

    sid_wr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (iFlush),
        .wdata_i ({iDelay, iAddr, iData}),
        .rdata_o (head),
        .level_o (oLevel),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        addr_d      = addr_q;
        data_d      = data_q;
        dropped_d   = dropped_q;
        if (iFlush) begin
            // oWE decodes state_q, so a WRITE cycle in progress still completes.
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        if (addr_writable(head_addr)) begin
                            pend_addr_d = head_addr;
                            pend_data_d = head_data;
                            cnt_d       = head_delay;
                            state_d     = ST_WAIT;
                        end else begin
                            dropped_d = 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!iPause && clkEn) begin
                        if (cnt_q == '0) begin
                            addr_d  = pend_addr_q;
                            data_d  = pend_data_q;
                            state_d = ST_WRITE;
                        end else begin
                            cnt_d = cnt_q - DELAY_W'(1);
                        end
                    end
                end
                ST_WRITE: state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            dropped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            dropped_q   <= dropped_d;
        end
    end

    assign oWE      = (state_q == ST_WRITE);
    assign oAddr    = addr_q;
    assign oData    = data_q;
    assign oBusy    = (state_q != ST_IDLE) || !fifo_empty;
    assign oDropped = dropped_q;

endmodule
